// File: rtl/io_bus_if.sv
// io_bus_if: datapath-to-I/O bus carrying the effective address, store data and store strobe
// towards the unit, and the window select and read data back to the datapath.
interface io_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        io_sel;
  logic [31:0] rdata;

  modport master (output addr, wdata, we, input io_sel, rdata);
  modport slave  (input addr, wdata, we, output io_sel, rdata);
endinterface

// File: rtl/io_bus_unit.sv
// io_bus_unit: memory-mapped I/O window (0x80..0xFF) with output registers, synchronised inputs,
// key-press flags and a multiplexed 8-digit display. Define IO_CYCLE_COUNTER_EN for the 0xC8 cycle counter.
module io_bus_unit #(
  parameter int SCAN_DIV = 16
) (
  input  logic        clock,
  input  logic        reset,
  io_bus_if.slave     bus,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [6:0]  seg,
  output logic [7:0]  an
);

  localparam logic [4:0] OFF_OUT0 = 5'd0;
  localparam logic [4:0] OFF_OUT1 = 5'd1;
  localparam logic [4:0] OFF_DISP = 5'd2;
  localparam logic [4:0] OFF_SW   = 5'd16;
  localparam logic [4:0] OFF_KEY  = 5'd17;
  localparam logic [4:0] OFF_CYC  = 5'd18;
  localparam logic [SCAN_DIV-1:0] SCAN_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  logic [31:0]         out0_r, out1_r, disp_r;
  logic [9:0]          sw_s1_r, sw_s2_r;
  logic [3:0]          k_s1_r, k_s2_r, k_s3_r, flag_r;
  logic [SCAN_DIV-1:0] scan_r;
  logic [6:0]          seg_r;
  logic [7:0]          an_r;
  logic                io_sel_s, wr_s, unused_s;
  logic [4:0]          off_s;
  logic [3:0]          fall_s, clr_s;
  logic [2:0]          digit_s;
  logic [31:0]         rdata_s, cycles_s;

  assign io_sel_s = (bus.addr[31:8] == 24'd0) & bus.addr[7];
  assign off_s    = bus.addr[6:2];
  assign wr_s     = bus.we & io_sel_s;
  assign fall_s   = k_s3_r & ~k_s2_r;
  assign clr_s    = (wr_s && (off_s == OFF_KEY)) ? bus.wdata[3:0] : 4'd0;
  assign digit_s  = scan_r[SCAN_DIV-1 -: 3];
  assign unused_s = ^bus.addr[1:0];

  // Writable registers, input synchronisers, key flags and display scan
  always_ff @(posedge clock) begin
    if (reset) begin
      out0_r  <= 32'd0;
      out1_r  <= 32'd0;
      disp_r  <= 32'd0;
      sw_s1_r <= 10'd0;
      sw_s2_r <= 10'd0;
      k_s1_r  <= 4'hF;
      k_s2_r  <= 4'hF;
      k_s3_r  <= 4'hF;
      flag_r  <= 4'd0;
      scan_r  <= {SCAN_DIV{1'b0}};
      an_r    <= 8'hFE;
      seg_r   <= 7'b1000000;
    end else begin
      if (wr_s && (off_s == OFF_OUT0)) out0_r <= bus.wdata;
      if (wr_s && (off_s == OFF_OUT1)) out1_r <= bus.wdata;
      if (wr_s && (off_s == OFF_DISP)) disp_r <= bus.wdata;
      sw_s1_r <= sw;
      sw_s2_r <= sw_s1_r;
      k_s1_r  <= key;
      k_s2_r  <= k_s1_r;
      k_s3_r  <= k_s2_r;
      // A press landing in the same cycle as a W1C clear keeps the flag set
      flag_r  <= (flag_r & ~clr_s) | fall_s;
      scan_r  <= scan_r + SCAN_ONE;
      an_r    <= ~(8'b0000_0001 << digit_s);
      seg_r   <= hex7(disp_r[{digit_s, 2'b00} +: 4]);
    end
  end

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycles_r;

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_r <= 32'd0;
    end else begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  assign cycles_s = cycles_r;
`else
  assign cycles_s = 32'd0;
`endif

  // Zero-latency read mux over registered state; single-cycle loads depend on it
  always_comb begin
    rdata_s = 32'd0;
    if (io_sel_s) begin
      case (off_s)
        OFF_OUT0: rdata_s = out0_r;
        OFF_OUT1: rdata_s = out1_r;
        OFF_DISP: rdata_s = disp_r;
        OFF_SW:   rdata_s = {22'd0, sw_s2_r};
        OFF_KEY:  rdata_s = {28'd0, flag_r};
        OFF_CYC:  rdata_s = cycles_s;
        default:  rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.io_sel = io_sel_s;
  assign bus.rdata  = rdata_s;
  assign out0       = out0_r;
  assign out1       = out1_r;
  assign seg        = seg_r;
  assign an         = an_r;

endmodule

// File: tb/tb_io_bus_unit.sv
// tb_io_bus_unit: directed vector table, multi-cycle corner sequences and a randomized run
// compared against an edge-by-edge behavioural model of the I/O unit.
module tb_io_bus_unit;
  localparam int SD = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [31:0] out0, out1;
  logic [6:0]  seg;
  logic [7:0]  an;

  io_bus_if bus ();

  io_bus_unit #(.SCAN_DIV(SD)) dut (
    .clock(clock), .reset(reset), .bus(bus), .sw(sw), .key(key),
    .out0(out0), .out1(out1), .seg(seg), .an(an)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Behavioural model: register values plus histories of sampled inputs
  logic [31:0] m_out0, m_out1, m_disp, m_cyc;
  logic [3:0]  m_flag;
  logic [3:0]  kq [3];
  logic [9:0]  sw_q [2];
  int          m_n;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_sel;
    logic [31:0] rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if ((a[31:8] == 24'd0) && a[7]) begin
      case (a[6:2])
        5'd0:  r = m_out0;
        5'd1:  r = m_out1;
        5'd2:  r = m_disp;
        5'd16: r = {22'd0, sw_q[1]};
        5'd17: r = {28'd0, m_flag};
`ifdef IO_CYCLE_COUNTER_EN
        5'd18: r = m_cyc;
`endif
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Advance model and DUT across one rising edge using the inputs currently applied
  task automatic tick();
    logic       wr;
    logic [4:0] off;
    logic [3:0] fall, clr, nib;
    int         dig;
    wr  = bus.we && (bus.addr[31:8] == 24'd0) && bus.addr[7];
    off = bus.addr[6:2];
    if (reset) begin
      m_out0 = 32'd0; m_out1 = 32'd0; m_disp = 32'd0; m_cyc = 32'd0;
      m_flag = 4'd0; m_n = 0; m_an = 8'hFE; m_seg = 7'h40;
      for (int i = 0; i < 3; i++) kq[i] = 4'hF;
      sw_q[0] = 10'd0; sw_q[1] = 10'd0;
    end else begin
      fall  = kq[2] & ~kq[1];
      clr   = (wr && off == 5'd17) ? bus.wdata[3:0] : 4'd0;
      dig   = (m_n % (1 << SD)) / (1 << (SD - 3));
      m_an  = ~(8'h01 << dig);
      nib   = 4'(m_disp >> (4 * dig));
      m_seg = HEX[nib];
      m_n++;
      if (wr && off == 5'd0) m_out0 = bus.wdata;
      if (wr && off == 5'd1) m_out1 = bus.wdata;
      if (wr && off == 5'd2) m_disp = bus.wdata;
      m_flag = (m_flag & ~clr) | fall;
      m_cyc  = m_cyc + 32'd1;
      kq[2] = kq[1]; kq[1] = kq[0]; kq[0] = key;
      sw_q[1] = sw_q[0]; sw_q[0] = sw;
    end
    @(posedge clock);
    #1;
  endtask

  logic [31:0] amap [8] = '{32'h80, 32'h84, 32'h88, 32'hC0, 32'hC4, 32'hC8, 32'h90, 32'hFC};
  logic [31:0] ra, c0;

  initial begin
    reset = 1'b1; sw = 10'd0; key = 4'hF;
    bus.addr = 32'h80; bus.wdata = 32'd0; bus.we = 1'b0;

    vt[0]  = '{32'h80,    32'h0,        1'b0, 1'b1, 32'h80, 32'h0};
    vt[1]  = '{32'h84,    32'hDEADBEEF, 1'b1, 1'b1, 32'h84, 32'hDEADBEEF};
    vt[2]  = '{32'h100,   32'h12345678, 1'b1, 1'b0, 32'h84, 32'hDEADBEEF};
    vt[3]  = '{32'h90,    32'hFFFFFFFF, 1'b1, 1'b1, 32'h90, 32'h0};
    vt[4]  = '{32'h90,    32'h0,        1'b0, 1'b1, 32'h84, 32'hDEADBEEF};
    vt[5]  = '{32'h80,    32'hA5A5A5A5, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5};
    vt[6]  = '{32'h83,    32'h11111111, 1'b1, 1'b1, 32'h80, 32'h11111111};
    vt[7]  = '{32'hC0,    32'hFFFFFFFF, 1'b1, 1'b1, 32'hC0, 32'h0};
    vt[8]  = '{32'h10080, 32'h0,        1'b1, 1'b0, 32'h80, 32'h11111111};
    vt[9]  = '{32'h7C,    32'h0,        1'b1, 1'b0, 32'h84, 32'hDEADBEEF};
    vt[10] = '{32'h88,    32'hCAFEF00D, 1'b1, 1'b1, 32'h88, 32'hCAFEF00D};
    vt[11] = '{32'hC8,    32'hFFFFFFFF, 1'b1, 1'b1, 32'h88, 32'hCAFEF00D};
    vt[12] = '{32'hC4,    32'hF,        1'b1, 1'b1, 32'hC4, 32'h0};
    vt[13] = '{32'hFC,    32'h0,        1'b0, 1'b1, 32'hFC, 32'h0};

    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_io_sel", {31'd0, bus.io_sel}, 32'd1);
    chk("rst_an", {24'd0, an}, 32'hFE);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    chk("rst_out0", out0, 32'h0);
    chk("rst_out1", out1, 32'h0);

    for (int i = 0; i < NV; i++) begin
      bus.addr = vt[i].addr; bus.wdata = vt[i].wdata; bus.we = vt[i].we; #1;
      chk($sformatf("vec%0d_io_sel", i), {31'd0, bus.io_sel}, {31'd0, vt[i].exp_sel});
      tick();
      bus.we = 1'b0; bus.addr = vt[i].rd_addr; #1;
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].exp_rd);
      chk($sformatf("vec%0d_out0", i), out0, m_out0);
      chk($sformatf("vec%0d_out1", i), out1, m_out1);
    end

    // Switch synchroniser latency
    sw = 10'h2A5; bus.addr = 32'hC0; #1;
    tick(); chk("sw_early", bus.rdata, 32'h0);
    tick(); chk("sw_sync", bus.rdata, 32'h2A5);

    // Held key sets its flag once, W1C clears, set beats a simultaneous clear
    bus.addr = 32'hC4; key = 4'b1011;
    tick(); chk("key_edge_k", bus.rdata, 32'h0);
    tick(); chk("key_edge_k1", bus.rdata, 32'h0);
    tick(); chk("key_edge_k2", bus.rdata, 32'h4);
    repeat (17) tick();
    chk("key_held", bus.rdata, 32'h4);
    bus.we = 1'b1; bus.wdata = 32'h4; tick(); bus.we = 1'b0;
    chk("key_w1c", bus.rdata, 32'h0);
    repeat (3) tick();
    chk("key_held_no_reset", bus.rdata, 32'h0);
    key = 4'hF; repeat (3) tick();
    key = 4'b1101; repeat (3) tick();
    chk("key1_set", bus.rdata, 32'h2);
    key = 4'hF; repeat (3) tick();
    key = 4'b1101; repeat (2) tick();
    bus.we = 1'b1; bus.wdata = 32'h2; tick();
    chk("key_set_beats_clr", bus.rdata, 32'h2);
    bus.wdata = 32'h0; tick(); bus.we = 1'b0;
    chk("key_w0_keeps", bus.rdata, 32'h2);
    key = 4'hF;

    // Display scan with a known phase after reset
    reset = 1'b1; tick(); reset = 1'b0;
    bus.addr = 32'h88; bus.wdata = 32'h76543210; bus.we = 1'b1; tick(); bus.we = 1'b0;
    repeat (4) tick();
    chk("disp_an_d2a", {24'd0, an}, 32'hFB); chk("disp_seg_d2a", {25'd0, seg}, 32'h24);
    tick();
    chk("disp_an_d2b", {24'd0, an}, 32'hFB); chk("disp_seg_d2b", {25'd0, seg}, 32'h24);
    tick();
    chk("disp_an_d3", {24'd0, an}, 32'hF7); chk("disp_seg_d3", {25'd0, seg}, 32'h30);
    repeat (8) tick();
    chk("disp_an_d7", {24'd0, an}, 32'h7F); chk("disp_seg_d7", {25'd0, seg}, 32'h78);
    repeat (2) tick();
    chk("disp_an_wrap", {24'd0, an}, 32'hFE); chk("disp_seg_wrap", {25'd0, seg}, 32'h40);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int k;
      if ($urandom_range(0, 3) == 0) key = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
      bus.we = ($urandom_range(0, 2) == 0);
      bus.wdata = $urandom;
      k = $urandom_range(0, 9);
      if (k < 8) bus.addr = amap[k] | 32'($urandom_range(0, 3));
      else bus.addr = $urandom;
      #1;
      chk("rnd_io_sel", {31'd0, bus.io_sel}, {31'd0, (bus.addr[31:8] == 24'd0) && bus.addr[7]});
      tick();
      chk("rnd_out0", out0, m_out0);
      chk("rnd_out1", out1, m_out1);
      chk("rnd_an", {24'd0, an}, {24'd0, m_an});
      chk("rnd_seg", {25'd0, seg}, {25'd0, m_seg});
      ra = 32'h80 | {25'd0, 5'($urandom_range(0, 31)), 2'($urandom)};
      bus.addr = ra; #1;
      chk($sformatf("rnd_rdata@%0h", ra), bus.rdata, exp_rd(ra));
    end
    key = 4'hF;

    // Counter read-back or its absence
`ifdef IO_CYCLE_COUNTER_EN
    bus.we = 1'b0; bus.addr = 32'hC8; #1;
    c0 = bus.rdata;
    repeat (10) tick();
    chk("cyc_delta", bus.rdata - c0, 32'd10);
    dut.cycles_r = 32'hFFFFFFFF; m_cyc = 32'hFFFFFFFF;
    tick();
    chk("cyc_wrap", bus.rdata, 32'h0);
`else
    bus.we = 1'b0; bus.addr = 32'hC8; #1;
    c0 = 32'd0;
    chk("c8_reads_zero", bus.rdata, c0);
`endif

    // Reset mid-operation with a concurrent store that must be ignored
    bus.addr = 32'h84; bus.we = 1'b1; bus.wdata = 32'h5;
    tick(); bus.we = 1'b0;
    bus.addr = 32'h80; bus.wdata = 32'hFFFFFFFF; bus.we = 1'b1; reset = 1'b1;
    tick(); bus.we = 1'b0;
    chk("mid_rst_out0", out0, 32'h0);
    chk("mid_rst_out1", out1, 32'h0);
    chk("mid_rst_an", {24'd0, an}, 32'hFE);
    chk("mid_rst_seg", {25'd0, seg}, 32'h40);
    reset = 1'b0; bus.addr = 32'hC4; #1;
    chk("mid_rst_flag", bus.rdata, 32'h0);
    bus.addr = 32'h88; #1;
    chk("mid_rst_disp", bus.rdata, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
